// File: rtl/sd_cmd_pkg.sv
// Shared constants, response-type encodings and FSM state codes for the SD CMD-line controller.
package sd_cmd_pkg;

    localparam int CMD_BITS       = 48;
    localparam int RSP_SHORT_BITS = 48;
    localparam int RSP_LONG_BITS  = 136;

    localparam int NCR_MAX_DEF  = 64;
    localparam int NCC_DEF      = 8;
    localparam int TURN_CYC_DEF = 2;

    // Wide enough for the longest frame (136) and every timing count.
    localparam int CNT_W = 8;

    localparam logic [1:0] RSP_NONE  = 2'b00;
    localparam logic [1:0] RSP_SHORT = 2'b01;
    localparam logic [1:0] RSP_LONG  = 2'b10;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_SEND       = 3'd1;
    localparam state_t ST_TURN       = 3'd2;
    localparam state_t ST_WAIT_START = 3'd3;
    localparam state_t ST_RECV       = 3'd4;
    localparam state_t ST_GAP        = 3'd5;

    // The reserved encoding 2'b11 behaves as "no response".
    function automatic logic [1:0] norm_rsp_type(input logic [1:0] t);
        return (t == 2'b11) ? RSP_NONE : t;
    endfunction

    function automatic logic [CNT_W-1:0] rsp_len(input logic [1:0] t);
        return (t == RSP_LONG) ? CNT_W'(RSP_LONG_BITS) : CNT_W'(RSP_SHORT_BITS);
    endfunction

endpackage

// File: rtl/sd_cmd_line_ctrl_if.sv
// Command-layer and pad-side signals of the SD CMD-line controller.
interface sd_cmd_line_ctrl_if;
    import sd_cmd_pkg::*;

    // Handshake: start is a one-cycle request that is taken only while busy=0;
    // the transaction owns the line until done pulses, and done coincides with busy=0.
    logic                     start;
    logic [CMD_BITS-1:0]      cmd_data;
    logic [1:0]               rsp_type;
    logic                     busy;
    logic                     done;
    logic                     timeout;
    logic [RSP_LONG_BITS-1:0] rsp_data;
    logic                     pad_in;
    logic                     pad_oen;
    logic                     pad_out;
    state_t                   dbg_state;

    modport master (
        output start, cmd_data, rsp_type, pad_out,
        input  busy, done, timeout, rsp_data, pad_in, pad_oen, dbg_state
    );

    modport slave (
        input  start, cmd_data, rsp_type, pad_out,
        output busy, done, timeout, rsp_data, pad_in, pad_oen, dbg_state
    );

endinterface

// File: rtl/sd_cmd_shifter.sv
// Loadable shift register: parallel-in/serial-out for the command, serial-in/parallel-out
// for the response, with a down-counter whose last flag marks the final shift.
module sd_cmd_shifter
    import sd_cmd_pkg::*;
#(
    parameter int W        = RSP_LONG_BITS,
    parameter int SOUT_BIT = CMD_BITS - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [W-1:0]     load_val,
    input  logic [CNT_W-1:0] load_len,
    input  logic             shift,
    input  logic             sin,
    output logic             sout,
    output logic [W-1:0]     pout,
    output logic             last
);

    logic [W-1:0]     sr;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= load_val;
            cnt <= load_len;
        end else if (shift) begin
            sr  <= {sr[W-2:0], sin};
            cnt <= (cnt != '0) ? cnt - CNT_W'(1) : '0;
        end
    end

    assign sout = sr[SOUT_BIT];
    assign pout = sr;
    // High while the shift about to happen is the final one of the loaded length.
    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/sd_cmd_line_ctrl.sv
// SD CMD-line sequencer: sends a 48-bit command, turns the line around, hunts for the
// response start bit and captures a short/long response or reports a timeout.
module sd_cmd_line_ctrl
    import sd_cmd_pkg::*;
#(
    parameter int NCR_MAX  = NCR_MAX_DEF,
    parameter int NCC      = NCC_DEF,
    parameter int TURN_CYC = TURN_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    sd_cmd_line_ctrl_if.slave bus
);

    state_t                   state;
    logic [1:0]               rtype;
    logic [CNT_W-1:0]         ctr;
    logic                     cap_pending;
    logic                     busy_r;
    logic                     done_r;
    logic                     timeout_r;
    logic [RSP_LONG_BITS-1:0] rsp_r;

    logic                     sh_load;
    logic [RSP_LONG_BITS-1:0] sh_val;
    logic [CNT_W-1:0]         sh_len;
    logic                     sh_shift;
    logic                     sh_sout;
    logic [RSP_LONG_BITS-1:0] sh_pout;
    logic                     sh_last;

    sd_cmd_shifter #(
        .W        (RSP_LONG_BITS),
        .SOUT_BIT (CMD_BITS - 1)
    ) u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load),
        .load_val (sh_val),
        .load_len (sh_len),
        .shift    (sh_shift),
        .sin      (bus.pad_out),
        .sout     (sh_sout),
        .pout     (sh_pout),
        .last     (sh_last)
    );

    // The shifter is reloaded with zeros before the response search, so a short
    // response ends up right-aligned with the upper bits clear.
    always_comb begin
        sh_load  = 1'b0;
        sh_val   = '0;
        sh_len   = '0;
        sh_shift = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    sh_load = 1'b1;
                    sh_val  = RSP_LONG_BITS'(bus.cmd_data);
                    sh_len  = CNT_W'(CMD_BITS);
                end
            end
            ST_SEND:       sh_shift = 1'b1;
            ST_TURN: begin
                if (ctr == '0) begin
                    sh_load = 1'b1;
                    sh_len  = rsp_len(rtype);
                end
            end
            ST_WAIT_START: sh_shift = !bus.pad_out;
            ST_RECV:       sh_shift = 1'b1;
            default:       ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            rtype       <= RSP_NONE;
            ctr         <= '0;
            cap_pending <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            rsp_r       <= '0;
        end else begin
            done_r <= 1'b0;
            // The final response bit lands in the shifter on the RECV exit edge; copy one edge later.
            if (cap_pending) begin
                rsp_r       <= sh_pout;
                cap_pending <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        rtype     <= norm_rsp_type(bus.rsp_type);
                        rsp_r     <= '0;
                        timeout_r <= 1'b0;
                        busy_r    <= 1'b1;
                        state     <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (sh_last) begin
                        if (rtype == RSP_NONE) begin
                            state <= ST_GAP;
                            ctr   <= CNT_W'(NCC - 1);
                        end else begin
                            state <= ST_TURN;
                            ctr   <= CNT_W'(TURN_CYC - 1);
                        end
                    end
                end
                ST_TURN: begin
                    if (ctr == '0) begin
                        state <= ST_WAIT_START;
                        ctr   <= CNT_W'(NCR_MAX - 1);
                    end else begin
                        ctr <= ctr - CNT_W'(1);
                    end
                end
                ST_WAIT_START: begin
                    if (!bus.pad_out) begin
                        state <= ST_RECV;
                    end else if (ctr == '0) begin
                        timeout_r <= 1'b1;
                        state     <= ST_GAP;
                        ctr       <= CNT_W'(NCC - 1);
                    end else begin
                        ctr <= ctr - CNT_W'(1);
                    end
                end
                ST_RECV: begin
                    if (sh_last) begin
                        state       <= ST_GAP;
                        ctr         <= CNT_W'(NCC - 1);
                        cap_pending <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (ctr == '0) begin
                        state  <= ST_IDLE;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                    end else begin
                        ctr <= ctr - CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Only SEND ever drives the line, so the card's response never meets contention.
    assign bus.pad_oen   = (state != ST_SEND);
    assign bus.pad_in    = (state == ST_SEND) ? sh_sout : 1'b1;
    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.timeout   = timeout_r;
    assign bus.rsp_data  = rsp_r;
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_sd_cmd_line_ctrl.sv
// Self-checking bench for sd_cmd_line_ctrl: cycle-accurate line model with an expected-result queue.
module tb_sd_cmd_line_ctrl;
    import sd_cmd_pkg::*;

    localparam int TB_NCR  = 64;
    localparam int TB_NCC  = 8;
    localparam int TB_TURN = 2;
    localparam int RW      = RSP_LONG_BITS + 1;
    localparam int BUDGET  = 400;

    logic clk;
    logic rst_n;

    sd_cmd_line_ctrl_if bus ();

    sd_cmd_line_ctrl #(
        .NCR_MAX  (TB_NCR),
        .NCC      (TB_NCC),
        .TURN_CYC (TB_TURN)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [RW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Called at a falling edge; start is sampled on the next rising edge (cycle 0).
    // rlen = number of response bits the card drives (0 = silent line), first at cycle rstart.
    task automatic run_txn(input logic [47:0] cmd, input logic [1:0] rt, input int rlen,
                           input logic [135:0] pat, input int rstart);
        logic [47:0]   sent;
        logic [RW-1:0] exp_res;
        int            exp_done;
        int            cyc;
        int            oen_low;
        int            oen_bad;
        bit            seen;
        bit            no_rsp;

        no_rsp = (rt == 2'b00) || (rt == 2'b11);
        if (no_rsp) begin
            exp_done = 1 + CMD_BITS + TB_NCC;
            exp_res  = '0;
        end else if (rlen == 0) begin
            exp_done = 1 + CMD_BITS + TB_TURN + TB_NCR + TB_NCC;
            exp_res  = {1'b1, 136'd0};
        end else begin
            exp_done = rstart + rlen + TB_NCC;
            exp_res  = {1'b0, pat};
        end
        exp_q.push_back(exp_res);
        exp_cyc_q.push_back(exp_done);

        bus.cmd_data = cmd;
        bus.rsp_type = rt;
        bus.start    = 1'b1;
        bus.pad_out  = 1'b1;
        sent    = ~cmd;
        cyc     = 0;
        oen_low = 0;
        oen_bad = 0;
        seen    = 1'b0;
        while (!seen && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            // A second request mid-command must be ignored.
            bus.start    = (cyc == 10);
            bus.cmd_data = (cyc == 10) ? ~cmd : cmd;
            if (cyc == 1) check("busy_set", RW'(bus.busy), RW'(1));
            if (bus.pad_oen == 1'b0) begin
                oen_low++;
                if (cyc >= 1 && cyc <= CMD_BITS) sent[CMD_BITS - cyc] = bus.pad_in;
                else oen_bad++;
            end
            if (rlen > 0 && cyc >= rstart && cyc < rstart + rlen)
                bus.pad_out = pat[rlen - 1 - (cyc - rstart)];
            else
                bus.pad_out = 1'b1;
            if (bus.done) begin
                seen = 1'b1;
                check("done_cyc", RW'(cyc), RW'(exp_cyc_q.pop_front()));
                check("rsp_timeout", {bus.timeout, bus.rsp_data}, exp_q.pop_front());
                check("busy_clr", RW'(bus.busy), RW'(0));
            end
        end
        if (!seen) begin
            check("done_seen", RW'(0), RW'(1));
            void'(exp_q.pop_front());
            void'(exp_cyc_q.pop_front());
        end
        check("tx_bits", RW'(sent), RW'(cmd));
        check("oen_low_cnt", RW'(oen_low), RW'(CMD_BITS));
        check("oen_outside", RW'(oen_bad), RW'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [135:0] long_pat;
        logic [135:0] rnd_pat;
        logic [47:0]  rnd_cmd;
        logic [47:0]  sent;
        int           cyc;
        int           dones;

        bus.start    = 1'b0;
        bus.cmd_data = '0;
        bus.rsp_type = 2'b00;
        bus.pad_out  = 1'b1;
        rst_n        = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", RW'(bus.busy), RW'(0));
        check("rst_done", RW'(bus.done), RW'(0));
        check("rst_oen", RW'(bus.pad_oen), RW'(1));
        check("rst_pad_in", RW'(bus.pad_in), RW'(1));
        check("rst_rsp", RW'(bus.rsp_data), RW'(0));
        check("rst_state", RW'(bus.dbg_state), RW'(ST_IDLE));
        rst_n = 1'b1;

        // No-response command, then back-to-back short, long, timeout and reserved-type runs.
        run_txn(48'h40_0000_0000_95, RSP_NONE, 0, '0, 0);
        run_txn(48'h48_0000_01AA_87, RSP_SHORT, 48, 136'(48'h08_0000_01AA_13), 54);
        long_pat = {8'h3F, {8{16'hAA55}}};
        run_txn(48'h42_0000_0000_4D, RSP_LONG, 136, long_pat, 54);
        run_txn(48'h77_0000_0000_65, RSP_SHORT, 0, '0, 0);
        run_txn(48'h40_0000_0000_95, 2'b11, 0, '0, 0);

        // Mid-transaction reset at command bit 20, with an ignored start during SEND.
        rnd_cmd = {16'($urandom_range(0, 65535)), 32'($urandom)};
        bus.cmd_data = rnd_cmd;
        bus.rsp_type = RSP_SHORT;
        bus.start    = 1'b1;
        sent = ~rnd_cmd;
        cyc  = 0;
        while (cyc < 21) begin
            @(negedge clk);
            cyc++;
            bus.start    = (cyc == 5);
            bus.cmd_data = (cyc == 5) ? ~rnd_cmd : rnd_cmd;
            if (bus.pad_oen == 1'b0) sent[CMD_BITS - cyc] = bus.pad_in;
        end
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_oen", RW'(bus.pad_oen), RW'(1));
        check("mid_rst_busy", RW'(bus.busy), RW'(0));
        check("mid_rst_done", RW'(bus.done), RW'(0));
        check("mid_bits", RW'(sent[47:27]), RW'(rnd_cmd[47:27]));
        rst_n = 1'b1;
        dones = 0;
        repeat (80) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("no_done_after_rst", RW'(dones), RW'(0));

        // A fresh transaction with a random short response.
        rnd_cmd = {16'($urandom_range(0, 65535)), 32'($urandom)};
        rnd_pat = 136'({1'b0, 15'($urandom_range(0, 32767)), 32'($urandom)});
        run_txn(rnd_cmd, RSP_SHORT, 48, rnd_pat, 49 + $urandom_range(0, 20));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sd_cmd_line_ctrl.md
Name: sd_cmd_line_ctrl

Overview:
- Sequences the SD CMD-line bidirectional pad (bidir_pad) for one command/response transaction.
- Serialises a 48-bit command onto the line, releases the line for turnaround, then waits for the card's response start bit.
- Captures a 48-bit (short) or 136-bit (long) response, or flags a timeout.
- Sits between the command-layer FSM (CRC/cmd assembly) and the pad instance.

Parameters:
- CMD_BITS, 48: command frame length, shifted MSB first.
- RSP_SHORT_BITS, 48: short response length, including the start bit.
- RSP_LONG_BITS, 136: long response length, including the start bit.
- NCR_MAX, 64: maximum cycles in WAIT_START before timeout.
- NCC, 8: released idle cycles after the transaction before done.
- TURN_CYC, 2: released turnaround cycles between command and response search.

Ports:
- clk  input  1  system clock, one clock domain; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  single-cycle request; sampled only when busy=0.
- cmd_data  input  CMD_BITS  command frame; captured on an accepted start.
- rsp_type  input  2  captured with start: 00 no response, 01 short, 10 long, 11 treated as 00.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle completion pulse.
- timeout  output  1  valid with done; 1 means no start bit seen.
- rsp_data  output  RSP_LONG_BITS  captured response, right-aligned; stable from done until the next accepted start.
- pad_in  output  1  value driven onto the line, connected to bidir_pad.in.
- pad_oen  output  1  connected to bidir_pad.oen. 0 = pad drives io from in. 1 = line released, io observed on out.
- pad_out  input  1  line value from bidir_pad.out.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE.
  - busy=0, done=0, timeout=0, rsp_data=0, pad_oen=1, pad_in=1.
  - Holds mid-transaction: the line is released on the next edge and no done is issued.
- States: IDLE, SEND, TURN, WAIT_START, RECV, GAP.
- IDLE:
  - pad_oen=1, pad_in=1.
  - On start=1: capture cmd_data and rsp_type, clear rsp_data and timeout, set busy=1, go to SEND.
  - The acceptance edge is cycle 0.
- SEND:
  - pad_oen=0.
  - pad_in = cmd bit CMD_BITS-1-k in cycle k+1, for k = 0..CMD_BITS-1.
  - After the last bit: rsp_type none -> GAP; otherwise -> TURN.
- TURN:
  - pad_oen=1 for TURN_CYC cycles; pad_out is ignored.
  - Then go to WAIT_START.
- WAIT_START:
  - Sample pad_out each cycle.
  - 0 -> store it as response bit 0 (MSB) and go to RECV.
  - After NCR_MAX cycles without a 0: set timeout=1 and go to GAP.
- RECV:
  - Shift pad_out in, MSB first, until the total captured bit count is RSP_SHORT_BITS or RSP_LONG_BITS, per the captured rsp_type.
  - A short response lands in rsp_data[47:0]; the upper bits stay 0.
  - Then go to GAP.
  - pad_oen stays 1 throughout.
- GAP:
  - NCC cycles with the line released.
  - Then return to IDLE with done=1 for one cycle.
  - busy=0 in that same cycle.
- start while busy=1 is ignored; there is no queueing.
- start in the done cycle is accepted; back-to-back transactions are legal.
- pad_oen never goes to 0 outside SEND (no contention during response).
- A 1→0 transition on pad_out in the first cycle of WAIT_START is a valid start bit.

Decomposition:
- Shared package sd_cmd_pkg holds:
  - rsp_type encodings (RSP_NONE, RSP_SHORT, RSP_LONG);
  - the state enum;
  - CMD_BITS / RSP_*_BITS constants.
- One natural sub-module: sd_cmd_shifter, a loadable parallel-in/serial-out and serial-in/parallel-out register with a bit counter and done flag.
- bidir_pad is instantiated by the parent, not inside this block.

Test Plan:
- Reset check: assert rst_n=0 for 2 cycles -> busy=0, done=0, pad_oen=1, pad_in=1, rsp_data=0.
- No-response command: start with cmd_data=48'h40_0000_0000_95, rsp_type=00, at cycle 0.
  - pad_oen=0 for cycles 1..48 with serial bits 0,1,0,0,0,0,0,0,...,1,0,0,1,0,1,0,1.
  - done=1, timeout=0 at cycle 57.
- Short response: rsp_type=01; the bench drives 48'h08_0000_01AA_13 MSB-first, starting 5 cycles after release.
  - done with rsp_data[47:0]=48'h08_0000_01AA_13, upper bits 0, timeout=0.
- Long response: rsp_type=10; the bench drives a 136-bit pattern 0x3F followed by alternating bytes.
  - All 136 bits match; pad_oen=1 throughout the response.
- Timeout: rsp_type=01 and the line held at 1.
  - done+timeout at cycle 1+48+TURN_CYC+NCR_MAX+NCC = 123; rsp_data=0.
- Mid-transaction reset and busy rejection:
  - Pulse start during SEND -> ignored.
  - Assert rst_n=0 at bit 20 -> next edge pad_oen=1, busy=0, no done pulse.
  - A fresh start then completes normally.
